fp32_to_int_seq: RTL and testbench

Multi-cycle converter from an IEEE-754 single-precision value to a signed 32-bit integer, rounding to nearest-even. It decodes the packed format (sign, exponent, hidden bit, fraction), which is the inverse of the normalize/pack step of the adder path. The mantissa is right-shifted iteratively with guard/sticky capture. Valid/ready handshakes on both sides let the block sit between the FPU result path and integer consumers.

---
 rtl/fpu_pkg.sv | 44 ++++
 rtl/fp32_unpack.sv | 60 ++++++
 rtl/fp32_to_int_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_fp32_to_int_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared single-precision definitions for the FPU datapaths: field widths,
// bias, integer saturation limits, the packed fp32 field view and the state
// encoding of the sequential float-to-int converter.
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;

    localparam logic [FP_EXP_W-1:0] FP_EXP_INF = 8'hFF;

    localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;

    // Exponent at which the hidden bit lands exactly on integer bit 0
    // (bias + fraction width = 150). Below it the mantissa shifts right.
    localparam logic [FP_EXP_W-1:0] RIGHT_EXP_BASE = 8'(FP_BIAS + FP_FRAC_W);

    // Smallest exponent whose magnitude no longer fits in int32 (2^31).
    localparam logic [FP_EXP_W-1:0] SAT_EXP = 8'(FP_BIAS + 31);

    // Right shifts of 25 or more leave only sticky information.
    localparam logic [4:0] MAX_RSHIFT = 5'd25;

    // -2^31 is the only value at SAT_EXP that is still representable.
    localparam logic [31:0] FP_NEG_2_31 = 32'hCF000000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/fp32_unpack.sv
// ---------------------------------------------------------------------------
// fp32_unpack
// Purely combinational field decoder for an IEEE-754 single-precision word.
// Ports:
//   i_a               fp32 operand {sign, exp, frac}
//   o_sign/o_exp/o_frac  raw fields
//   o_isNan           exp all ones, fraction nonzero
//   o_isInf           exp all ones, fraction zero
//   o_isZeroOrDenorm  exp zero
//   o_mant            24-bit mantissa with the hidden bit set
//   o_isRight         exponent below 150, so the mantissa must shift right
//   o_rshiftCnt       150 - exp, clamped to 25 (zero when o_isRight is low)
// ---------------------------------------------------------------------------
module fp32_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]          i_a,
    output logic                 o_sign,
    output logic [FP_EXP_W-1:0]  o_exp,
    output logic [FP_FRAC_W-1:0] o_frac,
    output logic                 o_isNan,
    output logic                 o_isInf,
    output logic                 o_isZeroOrDenorm,
    output logic [FP_FRAC_W:0]   o_mant,
    output logic                 o_isRight,
    output logic [4:0]           o_rshiftCnt
);

    fp32_t               w_fields;
    logic [FP_EXP_W-1:0] w_rightDiff;

    assign w_fields = i_a;

    assign o_sign = w_fields.sign;
    assign o_exp  = w_fields.exp;
    assign o_frac = w_fields.frac;

    assign o_isNan          = (w_fields.exp == FP_EXP_INF) && (w_fields.frac != '0);
    assign o_isInf          = (w_fields.exp == FP_EXP_INF) && (w_fields.frac == '0);
    assign o_isZeroOrDenorm = (w_fields.exp == '0);

    // Hidden bit is always set here; callers screen out zero/denormals first.
    assign o_mant = {1'b1, w_fields.frac};

    assign o_isRight   = (w_fields.exp < RIGHT_EXP_BASE);
    assign w_rightDiff = RIGHT_EXP_BASE - w_fields.exp;

    // Clamp so the shift counter stays 5 bits wide.
    always_comb begin
        o_rshiftCnt = 5'd0;
        if (o_isRight) begin
            if (w_rightDiff >= {3'b000, MAX_RSHIFT}) begin
                o_rshiftCnt = MAX_RSHIFT;
            end else begin
                o_rshiftCnt = w_rightDiff[4:0];
            end
        end
    end

endmodule

// File: rtl/fp32_to_int_seq.sv
// ---------------------------------------------------------------------------
// fp32_to_int_seq
// Multi-cycle fp32 -> signed int32 converter, round to nearest even.
// The mantissa is shifted right up to SHIFT_STEP bits per cycle while the
// discarded bits are folded into guard/sticky, then rounded in one cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/in_ready/in_a   operand handshake (accepted only in IDLE)
//   out_valid/out_ready      result handshake (result held until taken)
//   out_q           int32 result, two's complement
//   out_invalid     NaN, Inf or out-of-range operand
//   out_inexact     nonzero bits were discarded by rounding
// ---------------------------------------------------------------------------
module fp32_to_int_seq
    import fpu_pkg::*;
#(
    parameter int SHIFT_STEP = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_q,
    output logic        out_invalid,
    output logic        out_inexact
);

    localparam logic [4:0] STEP_N = 5'(SHIFT_STEP);

    conv_state_t r_state;
    conv_state_t w_nextState;

    logic [31:0] r_mag;
    logic [4:0]  r_rem;
    logic        r_guard;
    logic        r_sticky;
    logic        r_sign;
    logic [31:0] r_q;
    logic        r_invalid;
    logic        r_inexact;

    logic                 w_sign;
    logic [FP_EXP_W-1:0]  w_exp;
    logic [FP_FRAC_W-1:0] w_frac;
    logic                 w_isNan;
    logic                 w_isInf;
    logic                 w_isZeroOrDenorm;
    logic [FP_FRAC_W:0]   w_mant;
    logic                 w_isRight;
    logic [4:0]           w_rshiftCnt;

    logic        w_accept;
    logic        w_isSpecial;
    logic        w_isLeft;
    logic        w_isFarRight;
    logic [31:0] w_specQ;
    logic        w_specInvalid;
    logic        w_specInexact;
    logic [7:0]  w_leftAmt;
    logic [31:0] w_leftMag;

    logic [4:0]  w_stepN;
    logic [31:0] w_outMask;
    logic [31:0] w_lowMask;
    logic [31:0] w_magShifted;
    logic        w_guardNew;
    logic        w_stickyNew;

    logic        w_inc;
    logic [31:0] w_rounded;
    logic [31:0] w_signedQ;

    fp32_unpack u_unpack (
        .i_a              (in_a),
        .o_sign           (w_sign),
        .o_exp            (w_exp),
        .o_frac           (w_frac),
        .o_isNan          (w_isNan),
        .o_isInf          (w_isInf),
        .o_isZeroOrDenorm (w_isZeroOrDenorm),
        .o_mant           (w_mant),
        .o_isRight        (w_isRight),
        .o_rshiftCnt      (w_rshiftCnt)
    );

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_q       = r_q;
    assign out_invalid = r_invalid;
    assign out_inexact = r_inexact;

    assign w_accept = in_valid && in_ready;

    // Operand classification at accept time.
    assign w_isSpecial  = w_isNan || w_isInf || w_isZeroOrDenorm || (w_exp >= SAT_EXP);
    assign w_isLeft     = !w_isSpecial && !w_isRight;
    assign w_isFarRight = (w_rshiftCnt == MAX_RSHIFT);

    // Exponents 150..157 shift left by 0..7; the result stays below 2^31.
    assign w_leftAmt = w_exp - RIGHT_EXP_BASE;
    assign w_leftMag = {8'h00, w_mant} << w_leftAmt;

    // Results that bypass the shifter entirely.
    always_comb begin
        w_specQ       = 32'h0;
        w_specInvalid = 1'b0;
        w_specInexact = 1'b0;
        if (w_isNan) begin
            w_specQ       = INT_MAX;
            w_specInvalid = 1'b1;
        end else if (w_isInf) begin
            w_specQ       = w_sign ? INT_MIN : INT_MAX;
            w_specInvalid = 1'b1;
        end else if (w_isZeroOrDenorm) begin
            w_specQ       = 32'h0;
            w_specInexact = (w_frac != '0);
        end else if (in_a == FP_NEG_2_31) begin
            w_specQ       = INT_MIN;
        end else begin
            w_specQ       = w_sign ? INT_MIN : INT_MAX;
            w_specInvalid = 1'b1;
        end
    end

    // One shift step: the top discarded bit becomes the new guard, every bit
    // below it plus the previous guard collapses into sticky.
    assign w_stepN      = (r_rem > STEP_N) ? STEP_N : r_rem;
    assign w_outMask    = (32'd1 << w_stepN) - 32'd1;
    assign w_lowMask    = w_outMask >> 1;
    assign w_magShifted = r_mag >> w_stepN;
    assign w_guardNew   = |(r_mag & (w_outMask ^ w_lowMask));
    assign w_stickyNew  = r_sticky | r_guard | (|(r_mag & w_lowMask));

    // Round to nearest, ties to even; the magnitude cannot overflow here.
    assign w_inc     = r_guard & (r_sticky | r_mag[0]);
    assign w_rounded = r_mag + {31'h0, w_inc};
    assign w_signedQ = r_sign ? (32'h0 - w_rounded) : w_rounded;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_isSpecial) begin
                        w_nextState = DONE;
                    end else if (w_isLeft || w_isFarRight) begin
                        w_nextState = ROUND;
                    end else begin
                        w_nextState = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_rem == w_stepN) begin
                    w_nextState = ROUND;
                end
            end
            ROUND: begin
                w_nextState = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath and result registers; results only change on accept of a
    // special operand or in ROUND, so they are stable throughout DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag     <= 32'h0;
            r_rem     <= 5'd0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_sign    <= 1'b0;
            r_q       <= 32'h0;
            r_invalid <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign   <= w_sign;
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
                        r_rem    <= 5'd0;
                        r_mag    <= 32'h0;
                        if (w_isSpecial) begin
                            r_q       <= w_specQ;
                            r_invalid <= w_specInvalid;
                            r_inexact <= w_specInexact;
                        end else if (w_isLeft) begin
                            r_mag <= w_leftMag;
                        end else if (w_isFarRight) begin
                            r_sticky <= 1'b1;
                        end else begin
                            r_mag <= {8'h00, w_mant};
                            r_rem <= w_rshiftCnt;
                        end
                    end
                end
                SHIFT: begin
                    r_mag    <= w_magShifted;
                    r_guard  <= w_guardNew;
                    r_sticky <= w_stickyNew;
                    r_rem    <= r_rem - w_stepN;
                end
                ROUND: begin
                    r_q       <= w_signedQ;
                    r_invalid <= 1'b0;
                    r_inexact <= r_guard | r_sticky;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// ---------------------------------------------------------------------------
// tb_fp32_to_int_seq
// Directed vectors with hand-computed results for the fp32 -> int32
// converter, plus backpressure and mid-conversion reset scenarios.
// ---------------------------------------------------------------------------
module tb_fp32_to_int_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic        out_invalid;
    logic        out_inexact;

    int vecCount  = 0;
    int missCount = 0;

    fp32_to_int_seq #(.SHIFT_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_q       (out_q),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it, report it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present one operand, wait for the result and check it. Called right
    // after a posedge (+1) with the DUT idle. expLat of 0 skips the latency check.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] expQ, input logic expInv,
                                 input logic expInex, input int expLat);
        int lat;
        checkOutput({tag, ".ready"}, {31'h0, in_ready}, 32'h1);
        in_a     = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        if (expLat != 0) begin
            checkOutput({tag, ".latency"}, lat, expLat);
        end
        checkOutput({tag, ".q"}, out_q, expQ);
        checkOutput({tag, ".invalid"}, {31'h0, out_invalid}, {31'h0, expInv});
        checkOutput({tag, ".inexact"}, {31'h0, out_inexact}, {31'h0, expInex});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".released"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        int sawValid;
        int lat;
        int unstable;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset.valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset.ready", {31'h0, in_ready}, 32'h1);
        checkOutput("reset.q", out_q, 32'h0);
        checkOutput("reset.flags", {30'h0, out_invalid, out_inexact}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Rounding path: k = 150 - e, latency ceil(k/4)+2.
        applyStimulus("p1_5",   32'h3FC00000, 32'h00000002, 1'b0, 1'b1, 8);
        applyStimulus("p2_5",   32'h40200000, 32'h00000002, 1'b0, 1'b1, 8);
        applyStimulus("p3_5",   32'h40600000, 32'h00000004, 1'b0, 1'b1, 8);
        applyStimulus("m2_5",   32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b1, 8);
        applyStimulus("m0_75",  32'hBF400000, 32'hFFFFFFFF, 1'b0, 1'b1, 8);
        applyStimulus("p0_5",   32'h3F000000, 32'h00000000, 1'b0, 1'b1, 8);
        applyStimulus("p100",   32'h42C80000, 32'h00000064, 1'b0, 1'b0, 7);
        applyStimulus("p0_25",  32'h3E800000, 32'h00000000, 1'b0, 1'b1, 0);
        // Special cases, latency 1.
        applyStimulus("min32",  32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1);
        applyStimulus("p2e31",  32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
        applyStimulus("nan",    32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
        applyStimulus("nnan",   32'hFFC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
        applyStimulus("ninf",   32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1);
        applyStimulus("denorm", 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1);
        applyStimulus("negz",   32'h80000000, 32'h00000000, 1'b0, 1'b0, 1);
        // Left path, latency 2.
        applyStimulus("maxl",   32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 2);
        applyStimulus("p2e23",  32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2);

        // Backpressure: result held, input blocked while in DONE.
        in_a     = 32'h3FC00000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bp.valid", {31'h0, out_valid}, 32'h1);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            in_a     = 32'h42C80000;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (!out_valid || out_q !== 32'h2 || !out_inexact || out_invalid || in_ready) begin
                unstable++;
            end
        end
        checkOutput("bp.stable", unstable, 0);
        checkOutput("bp.q", out_q, 32'h00000002);
        // Keep a new operand pending across the handshake edge.
        in_a      = 32'h42C80000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp.idleAfterHs", {30'h0, in_ready, out_valid}, 32'h2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp.acceptNext", {31'h0, in_ready}, 32'h0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bp.nextLatency", lat, 7);
        checkOutput("bp.nextQ", out_q, 32'h00000064);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of SHIFT aborts with no result.
        in_a     = 32'h3FC00000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("abort.busy", {31'h0, in_ready}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("abort.idle", {30'h0, in_ready, out_valid}, 32'h2);
        checkOutput("abort.q", out_q, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid++;
        end
        checkOutput("abort.noResult", sawValid, 0);
        applyStimulus("p1_0", 32'h3F800000, 32'h00000001, 1'b0, 1'b0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
